frame_update_sched: RTL

- Schedules all writes to the 200-bit Tetris board register so they only happen during vertical blanking. The VGA pixel pipeline therefore never renders a half-updated board.
- Arbitrates three board writers: line-clear, user move/rotate, and gravity drop.
- Generates the gravity drop request internally from a frame count.
- Sits between the vsync blank output and the game-logic write engines, clocked by the pixel clock.

---
 rtl/frame_update_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/frame_update_sched.sv
// Board-write scheduler: grants the line-clear, move and gravity-drop writers
// only inside vertical blanking, at most MAX_GRANTS per blanking interval.
module frame_update_sched #(
   parameter int MAX_GRANTS = 4,
   parameter int TIMEOUT    = 255,
   parameter int GRAV_W     = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              vblank,
   input  logic [GRAV_W-1:0] gravity_period,
   input  logic              req_clear,
   input  logic              req_move,
   input  logic              done,
   output logic              gnt_clear,
   output logic              gnt_move,
   output logic              gnt_drop,
   output logic              drop_pending,
   output logic              frame_start,
   output logic              timeout_err,
   output logic [15:0]       frame_cnt
);

   // state  | meaning
   // IDLE   | outside a blanking window (or budget spent); waits for vb_rise
   // ARB    | blanking active; picks the next writer if budget remains
   // GRANT  | one writer owns the board until done or timeout

   localparam int CNT_W = $clog2(MAX_GRANTS + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_GRANT} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CLEAR, OWN_MOVE, OWN_DROP} owner_t;

   state_t             state, state_nxt;
   owner_t             owner, owner_nxt;
   logic [CNT_W-1:0]   gcnt, gcnt_nxt;
   logic [TMR_W-1:0]   tmr, tmr_nxt;
   logic               prefer_drop, prefer_drop_nxt;
   logic               to_evt;
   logic               drop_done;

   logic               vb_s1, vb_s2, vb_s3;
   logic               vb_rise, vb_fall;
   logic [GRAV_W-1:0]  grav_cnt;
   logic [GRAV_W:0]    grav_sum;
   logic               grav_tick;

   // vblank synchroniser; rise/fall events are registered so they land
   // three cycles after the input edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vb_s1       <= 1'b0;
         vb_s2       <= 1'b0;
         vb_s3       <= 1'b0;
         vb_rise     <= 1'b0;
         vb_fall     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         vb_s1       <= vblank;
         vb_s2       <= vb_s1;
         vb_s3       <= vb_s2;
         vb_rise     <= vb_s2 & ~vb_s3;
         vb_fall     <= ~vb_s2 & vb_s3;
         frame_start <= vb_fall;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         frame_cnt <= '0;
      else if (vb_rise)
         frame_cnt <= frame_cnt + 16'd1;
   end

   assign grav_sum  = {1'b0, grav_cnt} + {{GRAV_W{1'b0}}, 1'b1};
   assign grav_tick = vb_rise && (gravity_period != '0) &&
                      (grav_sum >= {1'b0, gravity_period});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grav_cnt <= '0;
      end else if (gravity_period == '0) begin
         grav_cnt <= '0;
      end else if (vb_rise) begin
         grav_cnt <= grav_tick ? '0 : grav_sum[GRAV_W-1:0];
      end
   end

   // a new tick beats a same-cycle drop completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_pending <= 1'b0;
      else if (grav_tick)
         drop_pending <= 1'b1;
      else if (drop_done)
         drop_pending <= 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         owner       <= OWN_NONE;
         gcnt        <= '0;
         tmr         <= '0;
         prefer_drop <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         owner       <= owner_nxt;
         gcnt        <= gcnt_nxt;
         tmr         <= tmr_nxt;
         prefer_drop <= prefer_drop_nxt;
         timeout_err <= to_evt;
      end
   end

   always_comb begin
      state_nxt       = state;
      owner_nxt       = owner;
      gcnt_nxt        = gcnt;
      tmr_nxt         = tmr;
      prefer_drop_nxt = prefer_drop;
      to_evt          = 1'b0;
      drop_done       = 1'b0;
      case (state)
         ST_IDLE: begin
            owner_nxt = OWN_NONE;
            if (vb_rise) begin
               gcnt_nxt  = '0;
               state_nxt = ST_ARB;
            end
         end
         ST_ARB: begin
            if (!vb_s3 || gcnt == CNT_W'(MAX_GRANTS)) begin
               state_nxt = ST_IDLE;
            end else if (req_clear || req_move || drop_pending) begin
               state_nxt = ST_GRANT;
               tmr_nxt   = TMR_W'(TIMEOUT - 1);
               if (req_clear)
                  owner_nxt = OWN_CLEAR;
               else if (req_move && (!drop_pending || !prefer_drop))
                  owner_nxt = OWN_MOVE;
               else
                  owner_nxt = OWN_DROP;
            end
         end
         ST_GRANT: begin
            if (done || tmr == '0) begin
               state_nxt = ST_ARB;
               owner_nxt = OWN_NONE;
               gcnt_nxt  = gcnt + {{(CNT_W-1){1'b0}}, 1'b1};
               to_evt    = ~done;
               drop_done = done && (owner == OWN_DROP);
               if (owner == OWN_MOVE)
                  prefer_drop_nxt = 1'b1;
               else if (owner == OWN_DROP)
                  prefer_drop_nxt = 1'b0;
            end else begin
               tmr_nxt = tmr - {{(TMR_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            owner_nxt = OWN_NONE;
         end
      endcase
   end

   // owner is only non-NONE while in GRANT, so the grants are one-hot or zero
   assign gnt_clear = (owner == OWN_CLEAR);
   assign gnt_move  = (owner == OWN_MOVE);
   assign gnt_drop  = (owner == OWN_DROP);

endmodule
